// File: rtl/conv_pkg.sv
// Shared widths and signed data types for the 5x5 streaming convolution engine.
package conv_pkg;
  localparam int IMG_W = 32;
  localparam int K     = 5;
  localparam int DW    = 8;
  localparam int OW    = 16;
  localparam int ACC_W = 21;

  typedef logic signed [DW-1:0] pix_t;
  typedef logic signed [DW-1:0] wgt_t;
  typedef logic signed [OW-1:0] res_t;
endpackage

// File: rtl/conv_if.sv
// Pixel, weight-write and result bundle; master = source/sink side, slave = engine.
interface conv_if;
  import conv_pkg::*;

  logic       iValid;
  logic       iWren;
  logic [4:0] iADDR;
  pix_t       iX;
  wgt_t       iW;
  res_t       oY;
  logic       oValid;

  modport master (output iValid, iWren, iADDR, iX, iW, input oY, oValid);
  modport slave  (input iValid, iWren, iADDR, iX, iW, output oY, oValid);
endinterface

// File: rtl/conv_line_buffer.sv
// Four raster lines plus a 5x5 window as one pixel shift chain, advancing only on iEn.
// Window taps are combinational from the chain; entry 0 of the chain is the newest pixel.
module conv_line_buffer
  import conv_pkg::*;
(
  input  logic iCLK,
  input  logic iEn,
  input  pix_t iX,
  output pix_t oWin [K*K]
);
  localparam int DEPTH = (K-1)*IMG_W + K;

  pix_t sr [DEPTH];

  always_ff @(posedge iCLK) begin
    if (iEn) begin
      sr[0] <= iX;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // Window slot r*K+c (r = 0 top row) sits (K-1-r) lines and (K-1-c) pixels behind the newest pixel.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign oWin[r*K+c] = sr[(K-1-r)*IMG_W + (K-1-c)];
    end
  end
endmodule

// File: rtl/convolution_top.sv
// 5x5 streaming correlation: result 2 edges after the completing pixel, no back-pressure.
// CONV_SAT_EN selects saturation of the 21-bit sum to 16 bits; otherwise the sum wraps.
module convolution_top #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int K     = conv_pkg::K,
  parameter int DW    = conv_pkg::DW,
  parameter int OW    = conv_pkg::OW
) (
  input  logic  iCLK,
  input  logic  iRSTn,
  conv_if.slave bus
);
  import conv_pkg::*;

  localparam int            NT   = K*K;
  localparam int            CW   = $clog2(IMG_W);
  localparam int            PW   = 2*DW;
  localparam logic [CW-1:0] LAST = CW'(IMG_W-1);
  localparam logic [CW-1:0] EDGE = CW'(K-1);
  localparam logic [4:0]    NTA  = 5'(NT);

  wgt_t                     w    [NT];
  pix_t                     win  [NT];
  logic signed [PW-1:0]     prod [NT];
  logic signed [ACC_W-1:0]  sum;
  logic signed [OW-1:0]     yNext;
  logic [CW-1:0]            col;
  logic [CW-1:0]            row;
  logic                     winVld;
  logic                     prodVld;

  conv_line_buffer u_lb (
    .iCLK (iCLK),
    .iEn  (bus.iValid),
    .iX   (bus.iX),
    .oWin (win)
  );

  always_ff @(posedge iCLK or posedge iRSTn) begin
    if (iRSTn) begin
      for (int i = 0; i < NT; i++) w[i] <= '0;
    end else if (bus.iWren && bus.iADDR < NTA) begin
      w[bus.iADDR] <= bus.iW;
    end
  end

  // Products reload every cycle so queued windows drain even while iValid is low.
  always_ff @(posedge iCLK) begin
    for (int i = 0; i < NT; i++) prod[i] <= PW'(win[i]) * PW'(w[i]);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NT; i++) sum = sum + ACC_W'(prod[i]);
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2**(OW-1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2**(OW-1)));

  always_comb begin
    if (sum > SMAX)      yNext = OW'(SMAX);
    else if (sum < SMIN) yNext = OW'(SMIN);
    else                 yNext = OW'(sum);
  end
`else
  assign yNext = OW'(sum);
`endif

  // winVld tags the window formed by the pixel accepted on this edge.
  always_ff @(posedge iCLK or posedge iRSTn) begin
    if (iRSTn) begin
      col        <= '0;
      row        <= '0;
      winVld     <= 1'b0;
      prodVld    <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oY     <= '0;
    end else begin
      winVld     <= bus.iValid && (row >= EDGE) && (col >= EDGE);
      prodVld    <= winVld;
      bus.oValid <= prodVld;
      if (prodVld) bus.oY <= yNext;
      if (bus.iValid) begin
        col <= (col == LAST) ? '0 : col + 1'b1;
        if (col == LAST) row <= (row == LAST) ? '0 : row + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_convolution_top.sv
// Directed bench for convolution_top: scoreboard of expected results and pulse edges.
module tb_convolution_top;
`ifdef CONV_SAT_EN
  localparam int POS = 32767;
  localparam int NEG = -32768;
`else
  localparam int POS = 10009;
  localparam int NEG = -13184;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  int ys[$];
  int ycyc[$];
  int expY[$];
  int expCyc[$];
  int last[$];
  int identRef[$];

  conv_if bus();

  convolution_top dut (
    .iCLK  (clk),
    .iRSTn (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.oValid) begin
      ys.push_back(int'(bus.oY));
      ycyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input int a, input int v);
    bus.iWren = 1'b1;
    bus.iADDR = 5'(a);
    bus.iW    = 8'(v);
    @(negedge clk);
    bus.iWren = 1'b0;
  endtask

  task automatic setAll(input int v);
    for (int a = 0; a < 25; a++) wr(a, v);
  endtask

  // One pixel at frame position p; y is the expected result if p completes a window.
  task automatic pix(input int x, input int p, input int y);
    bus.iValid = 1'b1;
    bus.iX     = 8'(x);
    @(negedge clk);
    bus.iValid = 1'b0;
    if ((p / 32) >= 4 && (p % 32) >= 4) begin
      expCyc.push_back(cyc + 2);
      expY.push_back(y);
    end
  endtask

  task automatic drain(input string tag, input int n, input int first);
    int badv;
    int badt;
    repeat (4) @(negedge clk);
    badv = 0;
    badt = 0;
    check({tag, "_count"}, ys.size(), n);
    check({tag, "_first"}, (ys.size() > 0) ? ys[0] : -99999, first);
    for (int i = 0; i < ys.size() && i < expY.size(); i++) begin
      if (ys[i] != expY[i]) badv++;
      if (ycyc[i] != expCyc[i]) badt++;
    end
    check({tag, "_values"}, badv, 0);
    check({tag, "_timing"}, badt, 0);
    last = ys;
    ys.delete();
    ycyc.delete();
    expY.delete();
    expCyc.delete();
  endtask

  initial begin
    int bad;
    bus.iValid = 1'b0;
    bus.iWren  = 1'b0;
    bus.iADDR  = '0;
    bus.iX     = '0;
    bus.iW     = '0;
    repeat (3) @(negedge clk);
    check("rst_ovalid", int'(bus.oValid), 0);
    check("rst_oy", int'(bus.oY), 0);
    rst = 1'b0;
    @(negedge clk);

    // Six back-to-back all-ones frames: every window sums to 25.
    setAll(1);
    for (int f = 0; f < 6; f++)
      for (int p = 0; p < 1024; p++) pix(1, p, 25);
    drain("b2b", 4704, 25);

    // Identity kernel, x = index mod 128: result equals x[r+2][c+2].
    for (int a = 0; a < 25; a++) wr(a, (a == 12) ? 1 : 0);
    wr(27, 99);
    for (int p = 0; p < 1024; p++) pix(p % 128, p, (p - 66) % 128);
    drain("ident", 784, 66);
    identRef = last;

    // Same frame with random idle gaps between pixels.
    for (int p = 0; p < 1024; p++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pix(p % 128, p, (p - 66) % 128);
    end
    drain("gap", 784, 66);
    bad = (last.size() > identRef.size()) ? last.size() - identRef.size()
                                          : identRef.size() - last.size();
    for (int i = 0; i < last.size() && i < identRef.size(); i++)
      if (last[i] != identRef[i]) bad++;
    check("gap_vs_nogap", bad, 0);

    // Positive overflow on the first window of a new frame.
    setAll(127);
    for (int p = 0; p <= 132; p++) pix(127, p, POS);
    drain("posov", 1, POS);

    // Reset while a result pulse is on the output.
    pix(127, 133, POS);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_ovalid", int'(bus.oValid), 1);
    rst = 1'b1;
    #1;
    check("rst_clr_ovalid", int'(bus.oValid), 0);
    check("rst_clr_oy", int'(bus.oY), 0);
    @(negedge clk);
    rst = 1'b0;
    expY.delete();
    expCyc.delete();
    repeat (4) @(negedge clk);
    check("no_stale", ys.size(), 0);

    // After reset: weights are zero and the frame restarts at row 0, col 0.
    for (int p = 0; p <= 132; p++) pix(127, p, 0);
    drain("rstw", 1, 0);

    // Negative overflow on the next window (row 4, col 5).
    setAll(-128);
    pix(127, 133, NEG);
    drain("negov", 1, NEG);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/convolution_top.md
# convolution_top

Streaming 5×5 2-D convolution engine for 8-bit signed raster images, 32 pixels wide. It sits between a pixel source and a result sink. Pixels arrive one per enabled clock in raster order, and kernel weights are loaded through a small write port. The block emits one 16-bit signed result per fully-covered window position, giving 28×28 = 784 results per 32×32 frame. Frames stream back-to-back with no gap.

## Interface
Parameters:
- IMG_W, default 32: image width and height in pixels.
- K, default 5: kernel size (K×K).
- DW, default 8: pixel and weight width, signed.
- OW, default 16: output width, signed.

Ports:
- iCLK, input, 1: single clock. All state updates on the rising edge.
- iRSTn, input, 1: asynchronous reset, active-high. Despite the name, 1 means reset asserted.
- iValid, input, 1: iX carries a valid pixel this cycle.
- iWren, input, 1: write iW into weight slot iADDR.
- iADDR, input, 5: weight index, computed as kr*5+kc with kr = kernel row (0 = top) and kc = kernel column (0 = left). Values 25–31 are ignored.
- iX, input, DW: signed pixel.
- iW, input, DW: signed weight.
- oY, output, OW: signed convolution result.
- oValid, output, 1: oY is valid this cycle. It is a one-cycle qualifier with no back-pressure.

## Operation
- **Weight store:** 25×DW registers. When iWren=1 and iADDR<25, set w[iADDR] <= iW. Writes are independent of iValid.
- **Position counters:** col and row, each 0..31. Each accepted pixel (iValid=1) increments col. When col wraps 31→0, row increments. When row wraps 31→0, the next frame starts immediately.
- **Line buffer:** holds the 4 previous rows of 32 pixels each. Together with the incoming pixel it feeds a 5×5 window shift register. Both shift only on accepted pixels.
- **Window condition:** a window is complete when the accepted pixel has row≥4 and col≥4. Windows that straddle a row or frame boundary are never flagged valid.
- **Result:** correlation, not flipped. The result for top-left image position (r,c) is y(r,c) = Σ over i,j in 0..4 of x[r+i][c+j]·w[i*5+j].
- **Arithmetic:** products are 16-bit signed. The sum is accumulated at full width, 21 bits signed, then reduced to OW bits as described under Configuration.
- **Output count:** exactly 784 results per frame, in raster order of (r,c).
- **iValid=0:** counters, line buffer and window hold their values. In-flight pipeline stages still drain.

## Timing
- **Pipeline:** stage 1 registers the window and products. Stage 2 registers the adder-tree sum into oY.
- **Latency:** for a completing pixel accepted at edge N, oY and oValid are valid after edge N+2, with oValid high for exactly one cycle.
- **Weight timing:** a weight written at edge N is used by every window whose stage-1 register is loaded at edge N+1 or later.
- **Reset values:** oY=0, oValid=0, counters=0, weights=0, pipeline valid bits=0. Line-buffer data is don't-care.
- **Reset mid-frame:** the frame is abandoned. The next accepted pixel is treated as row 0, col 0. No oValid is produced from data accepted before reset.
- **Pixel index 132** (row 4, col 4) produces the first oValid of each frame.

## Configuration
- **CONV_SAT_EN defined:** the 21-bit sum saturates to the range [-32768, 32767].
- **CONV_SAT_EN undefined:** oY is the low 16 bits of the sum (two's-complement wrap).

## Structure
- **Shared package conv_pkg:** holds IMG_W, K, DW, OW, the accumulator width ACC_W=21, and a typedef for the signed pixel and weight types.
- **Sub-module conv_line_buffer:** (K-1)×IMG_W shift storage plus the K×K window output, with shift enable tied to iValid.
- **Top module:** weight store, counters, MAC/adder tree and output register.

## Test plan
- **All ones:** all 25 weights = 1, iX = 1 for a full frame. Expect 784 results, each oY = 25.
- **Identity kernel:** w[12] = 1, all other weights 0, iX = pixel index mod 128. Expect first oY = 66 (from pixel 2*32+2), and each oY equals x[r+2][c+2].
- **Positive overflow:** all weights 127, iX = 127 (sum 403225). Expect oY = 32767 with CONV_SAT_EN, or 10009 without it.
- **Negative overflow:** all weights -128, iX = 127 (sum -406400). Expect oY = -32768 with CONV_SAT_EN, or -13184 without it.
- **Back-to-back frames:** 6 consecutive frames of 1024 pixels. Expect exactly 4704 oValid pulses, the first 2 edges after pixel 132 of each frame, and none for col<4 or row<4.
- **Stall and reset:** random iValid gaps give results identical to the no-gap run. Asserting iRSTn mid-frame clears oValid immediately, and the next frame restarts at row 0, col 0.
